alu_shift_stage: RTL

Pipelined shift execution stage of the 32-bit ALU. It accepts shift requests over a valid/ready handshake and registers the operands. It computes SRL, SRA, SLL and ROR using two instances of the existing combinational 32-bit logical right shifter (Right_32: in[31:0], ctrl[4:0], out[31:0]), then returns a registered result with a zero flag and a pass-through tag. It sits between the ALU operand/issue logic upstream and result writeback downstream.

---
 rtl/alu_shift_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_shift_stage.sv
// Two-stage pipelined shift unit (SRL/SRA/SLL/ROR) built from two logical
// right shifters, with valid/ready flow control, flush and a pass-through tag.

module Right_32 (
  input  logic [31:0] in,
  input  logic [4:0]  ctrl,
  output logic [31:0] out
);
  assign out = in >> ctrl;
endmodule

module alu_shift_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [4:0]       in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] res;
    for (int i = 0; i < 32; i++) res[i] = v[31-i];
    return res;
  endfunction

  logic             r_s1_valid;
  logic [31:0]      r_s1_data;
  logic [4:0]       r_s1_shamt;
  logic [1:0]       r_s1_op;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_out_valid;
  logic [31:0]      r_out_data;
  logic             r_out_zero;
  logic [TAG_W-1:0] r_out_tag;

  logic        w_s2_free;
  logic        w_s1_adv;
  logic        w_accept;
  logic        w_is_sll;
  logic [31:0] w_a_in;
  logic [31:0] w_a_out;
  logic [31:0] w_r;
  logic [31:0] w_b_in;
  logic [4:0]  w_b_ctrl;
  logic [31:0] w_b_out;
  logic [31:0] w_result;
  logic        w_zero;

  assign w_s2_free = !r_out_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign in_ready  = !flush && (!r_s1_valid || w_s2_free);
  assign w_accept  = in_valid && in_ready;

  // SLL is a right shift of the bit-reversed operand, reversed back.
  assign w_is_sll = (r_s1_op == OP_SLL);
  assign w_a_in   = w_is_sll ? bit_rev(r_s1_data) : r_s1_data;

  Right_32 u_shift_a (
    .in   (w_a_in),
    .ctrl (r_s1_shamt),
    .out  (w_a_out)
  );

  assign w_r = w_is_sll ? bit_rev(w_a_out) : w_a_out;

  always_comb begin
    w_b_in   = '0;
    w_b_ctrl = '0;
    case (r_s1_op)
      OP_SRA: begin
        w_b_in   = '1;
        w_b_ctrl = r_s1_shamt;
      end
      OP_ROR: begin
        // Left shift by (32 - shamt) mod 32 supplies the wrapped-around bits.
        w_b_in   = bit_rev(r_s1_data);
        w_b_ctrl = 5'd0 - r_s1_shamt;
      end
      default: begin
        w_b_in   = '0;
        w_b_ctrl = '0;
      end
    endcase
  end

  Right_32 u_shift_b (
    .in   (w_b_in),
    .ctrl (w_b_ctrl),
    .out  (w_b_out)
  );

  always_comb begin
    w_result = w_r;
    case (r_s1_op)
      OP_SRL: w_result = w_r;
      OP_SLL: w_result = w_r;
      OP_SRA: w_result = w_r | (r_s1_data[31] ? ~w_b_out : 32'h0);
      OP_ROR: w_result = w_r | bit_rev(w_b_out);
      default: w_result = w_r;
    endcase
  end

  assign w_zero = (w_result == 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_shamt <= '0;
      r_s1_op    <= '0;
      r_s1_tag   <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= in_data;
      r_s1_shamt <= in_shamt;
      r_s1_op    <= in_op;
      r_s1_tag   <= in_tag;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zero  <= 1'b0;
      r_out_tag   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_zero  <= w_zero;
      r_out_tag   <= r_s1_tag;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_zero  = r_out_zero;
  assign out_tag   = r_out_tag;

endmodule
